// File: rtl/snake_pkg.sv
// Shared definitions for the snake body engine: direction codes, FSM states
// and the reversal helper.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'd0;
    localparam logic [1:0] DIR_LEFT  = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_UP    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    // Axis pairs differ only in bit 0 (right/left, down/up).
    function automatic logic [1:0] opposite(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_cell_match.sv
// Compares one cell against every live segment in parallel and reports the
// lowest matching index; entries at or beyond count are masked off.
module snake_cell_match
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int XW      = 6,
    parameter int YW      = 6,
    parameter int LW      = 5
) (
    input  logic [MAX_LEN-1:0][XW-1:0] seg_x,
    input  logic [MAX_LEN-1:0][YW-1:0] seg_y,
    input  logic [LW-1:0]              count,
    input  logic [XW-1:0]              cell_x,
    input  logic [YW-1:0]              cell_y,
    output logic                       hit,
    output logic [LW-1:0]              idx
);

    // Scanning downward lets the lowest index overwrite any higher match.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = MAX_LEN - 1; i >= 0; i--) begin
            if ((LW'(i) < count) && (seg_x[i] == cell_x) && (seg_y[i] == cell_y)) begin
                hit = 1'b1;
                idx = LW'(i);
            end
        end
    end

endmodule

// File: rtl/snake_engine.sv
// Snake body engine: segment storage, stepping, growth, wall/self collision
// and a registered cell lookup for the pixel pipeline.
//
// state  | meaning
// S_IDLE | after reset, body loaded but not moving; waits for init
// S_RUN  | body advances one cell per step pulse
// S_DEAD | fatal step taken, body frozen; init restarts
module snake_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 4,
    parameter int XW       = $clog2(GRID_W),
    parameter int YW       = $clog2(GRID_H),
    parameter int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          step,
    input  logic          dir_valid,
    input  logic [1:0]    dir,
    input  logic          grow,
    input  logic [XW-1:0] query_x,
    input  logic [YW-1:0] query_y,
    output logic          query_hit,
    output logic [LW-1:0] query_seg,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          running,
    output logic          died
);

    function automatic logic [MAX_LEN-1:0][XW-1:0] init_body_x();
        logic [MAX_LEN-1:0][XW-1:0] v;
        v = '0;
        for (int i = 0; i < INIT_LEN; i++) begin
            v[i] = XW'(INIT_LEN - 1 - i);
        end
        return v;
    endfunction

    localparam logic [MAX_LEN-1:0][XW-1:0] INIT_X = init_body_x();
    localparam logic [XW:0]   GW_LIM  = (XW + 1)'(GRID_W);
    localparam logic [YW:0]   GH_LIM  = (YW + 1)'(GRID_H);
    localparam logic [XW:0]   ONE_X   = (XW + 1)'(1);
    localparam logic [YW:0]   ONE_Y   = (YW + 1)'(1);
    localparam logic [LW-1:0] ONE_L   = LW'(1);
    localparam logic [LW-1:0] MAX_L   = LW'(MAX_LEN);
    localparam logic [LW-1:0] INIT_L  = LW'(INIT_LEN);

    logic [MAX_LEN-1:0][XW-1:0] seg_x;
    logic [MAX_LEN-1:0][YW-1:0] seg_y;
    state_t        state, state_next;
    logic [1:0]    cur_dir, pend_dir, pend_dir_next, eff_dir;
    logic          grow_pend;
    logic [LW-1:0] len_q;
    logic          running_q, running_next;
    logic          died_q;

    logic [XW:0]   nhx;
    logic [YW:0]   nhy;
    logic          step_ok, grow_eff, wall_hit, self_hit, fatal;
    logic [LW-1:0] self_lim;
    logic          self_match;
    logic [LW-1:0] self_idx;
    logic          q_hit_c;
    logic [LW-1:0] q_seg_c;

    snake_cell_match #(
        .MAX_LEN (MAX_LEN),
        .XW      (XW),
        .YW      (YW),
        .LW      (LW)
    ) u_query_match (
        .seg_x  (seg_x),
        .seg_y  (seg_y),
        .count  (len_q),
        .cell_x (query_x),
        .cell_y (query_y),
        .hit    (q_hit_c),
        .idx    (q_seg_c)
    );

    // The tail only stays put when the body actually lengthens this step.
    snake_cell_match #(
        .MAX_LEN (MAX_LEN),
        .XW      (XW),
        .YW      (YW),
        .LW      (LW)
    ) u_self_match (
        .seg_x  (seg_x),
        .seg_y  (seg_y),
        .count  (self_lim),
        .cell_x (nhx[XW-1:0]),
        .cell_y (nhy[YW-1:0]),
        .hit    (self_match),
        .idx    (self_idx)
    );

    always_comb begin
        step_ok  = step && !init && (state == S_RUN);
        grow_eff = grow_pend && (len_q < MAX_L);
        self_lim = grow_eff ? len_q : (len_q - ONE_L);

        // One extra bit so a move off the low edge reads as all-ones.
        nhx = {1'b0, seg_x[0]};
        nhy = {1'b0, seg_y[0]};
        case (pend_dir)
            DIR_RIGHT: nhx = nhx + ONE_X;
            DIR_LEFT:  nhx = nhx - ONE_X;
            DIR_DOWN:  nhy = nhy + ONE_Y;
            default:   nhy = nhy - ONE_Y;
        endcase

        wall_hit = (nhx >= GW_LIM) || (nhy >= GH_LIM);
        self_hit = self_match && (self_idx != '0);
        fatal    = step_ok && (wall_hit || self_hit);

        state_next = state;
        if (init) begin
            state_next = S_RUN;
        end else if (fatal) begin
            state_next = S_DEAD;
        end
        running_next = (state_next == S_RUN);

        // Reversal is judged against the heading in force after this cycle.
        eff_dir       = step_ok ? pend_dir : cur_dir;
        pend_dir_next = pend_dir;
        if (init) begin
            pend_dir_next = DIR_RIGHT;
        end else if (dir_valid && (dir != opposite(eff_dir))) begin
            pend_dir_next = dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            running_q <= 1'b0;
        end else begin
            state     <= state_next;
            running_q <= running_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_x     <= INIT_X;
            seg_y     <= '0;
            len_q     <= INIT_L;
            cur_dir   <= DIR_RIGHT;
            pend_dir  <= DIR_RIGHT;
            grow_pend <= 1'b0;
            died_q    <= 1'b0;
            query_hit <= 1'b0;
            query_seg <= '0;
        end else begin
            query_hit <= q_hit_c;
            query_seg <= q_seg_c;
            died_q    <= fatal;
            pend_dir  <= pend_dir_next;

            if (init) begin
                seg_x     <= INIT_X;
                seg_y     <= '0;
                len_q     <= INIT_L;
                cur_dir   <= DIR_RIGHT;
                grow_pend <= 1'b0;
            end else begin
                if (grow) begin
                    grow_pend <= 1'b1;
                end else if (step_ok) begin
                    grow_pend <= 1'b0;
                end
                if (step_ok) begin
                    cur_dir <= pend_dir;
                end
                if (step_ok && !fatal) begin
                    seg_x <= {seg_x[MAX_LEN-2:0], nhx[XW-1:0]};
                    seg_y <= {seg_y[MAX_LEN-2:0], nhy[YW-1:0]};
                    if (grow_eff) begin
                        len_q <= len_q + ONE_L;
                    end
                end
            end
        end
    end

    assign head_x  = seg_x[0];
    assign head_y  = seg_y[0];
    assign length  = len_q;
    assign running = running_q;
    assign died    = died_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: directed scenarios plus a randomized run checked
// against a queue-based model of the snake body.
module tb_snake_engine;

    localparam int GW = 64;
    localparam int GH = 48;
    localparam int ML = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init = 1'b0;
    logic       step = 1'b0;
    logic       dir_valid = 1'b0;
    logic [1:0] dir = 2'd0;
    logic       grow = 1'b0;
    logic [5:0] query_x = '0;
    logic [5:0] query_y = '0;
    logic       query_hit;
    logic [4:0] query_seg;
    logic [5:0] head_x;
    logic [5:0] head_y;
    logic [4:0] length;
    logic       running;
    logic       died;

    snake_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .step      (step),
        .dir_valid (dir_valid),
        .dir       (dir),
        .grow      (grow),
        .query_x   (query_x),
        .query_y   (query_y),
        .query_hit (query_hit),
        .query_seg (query_seg),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .running   (running),
        .died      (died)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: body as queues, head at the front.
    int mx[$];
    int my[$];
    int m_state;   // 0 idle, 1 run, 2 dead
    int m_cur, m_pend;
    bit m_gp, m_died;
    bit e_hit;
    int e_seg;

    function automatic bit is_opp(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) ||
               (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    task automatic m_reset_body();
        mx = '{3, 2, 1, 0};
        my = '{0, 0, 0, 0};
        m_cur  = 0;
        m_pend = 0;
        m_gp   = 0;
    endtask

    task automatic m_reset_model();
        m_reset_body();
        m_state = 0;
        m_died  = 0;
        e_hit   = 0;
        e_seg   = 0;
    endtask

    task automatic m_query(input int qx, input int qy);
        e_hit = 0;
        e_seg = 0;
        for (int i = 0; i < mx.size(); i++) begin
            if (!e_hit && mx[i] == qx && my[i] == qy) begin
                e_hit = 1;
                e_seg = i;
            end
        end
    endtask

    task automatic m_step();
        int nx, ny, lim;
        bit grows, fatal;
        m_cur = m_pend;
        nx = mx[0];
        ny = my[0];
        case (m_cur)
            0: nx = nx + 1;
            1: nx = nx - 1;
            2: ny = ny + 1;
            default: ny = ny - 1;
        endcase
        grows = m_gp && (mx.size() < ML);
        fatal = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
        lim = grows ? mx.size() - 1 : mx.size() - 2;
        for (int i = 1; i <= lim; i++) begin
            if (mx[i] == nx && my[i] == ny) fatal = 1;
        end
        m_gp = 0;
        if (fatal) begin
            m_state = 2;
            m_died  = 1;
        end else begin
            mx.push_front(nx);
            my.push_front(ny);
            if (!grows) begin
                void'(mx.pop_back());
                void'(my.pop_back());
            end
        end
    endtask

    task automatic drive_cycle(input bit i_init, input bit i_step, input bit i_dv,
                               input int i_dir, input bit i_grow, input int qx, input int qy);
        init      = i_init;
        step      = i_step;
        dir_valid = i_dv;
        dir       = 2'(i_dir);
        grow      = i_grow;
        query_x   = 6'(qx);
        query_y   = 6'(qy);
        m_query(qx, qy);
        @(posedge clk);
        #1;
        init      = 1'b0;
        step      = 1'b0;
        dir_valid = 1'b0;
        grow      = 1'b0;
        m_died    = 0;
        if (i_init) begin
            m_reset_body();
            m_state = 1;
        end else begin
            if (i_dv && !is_opp(i_dir, m_cur)) m_pend = i_dir;
            if (i_grow) m_gp = 1;
            if (i_step && m_state == 1) m_step();
        end
    endtask

    task automatic do_init();            drive_cycle(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_step();            drive_cycle(0, 1, 0, 0, 0, 0, 0); endtask
    task automatic do_dir(input int d);  drive_cycle(0, 0, 1, d, 0, 0, 0); endtask
    task automatic do_grow();            drive_cycle(0, 0, 0, 0, 1, 0, 0); endtask
    task automatic do_query(input int x, input int y); drive_cycle(0, 0, 0, 0, 0, x, y); endtask

    task automatic test_reset();
        n_cmp++;
        if (head_x !== 6'd3 || head_y !== 6'd0 || length !== 5'd4 || running !== 1'b0 ||
            died !== 1'b0 || query_hit !== 1'b0 || query_seg !== 5'd0) begin
            n_bad++;
            $display("FAIL reset_state: head=(%0d,%0d) len=%0d run=%0b died=%0b qhit=%0b qseg=%0d want (3,0) 4 0 0 0 0",
                     head_x, head_y, length, running, died, query_hit, query_seg);
        end
        do_step();
        n_cmp++;
        if (head_x !== 6'd3 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_step_ignored: head_x=%0d run=%0b want 3 0", head_x, running);
        end
    endtask

    task automatic test_basic();
        do_init();
        repeat (3) do_step();
        n_cmp++;
        if (head_x !== 6'd6 || head_y !== 6'd0 || length !== 5'd4 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_move: head=(%0d,%0d) len=%0d run=%0b want (6,0) 4 1",
                     head_x, head_y, length, running);
        end
        do_query(3, 0);
        n_cmp++;
        if (query_hit !== 1'b1 || query_seg !== 5'd3) begin
            n_bad++;
            $display("FAIL query_tail: hit=%0b seg=%0d want 1 3", query_hit, query_seg);
        end
        do_query(2, 0);
        n_cmp++;
        if (query_hit !== 1'b0) begin
            n_bad++;
            $display("FAIL query_vacated: hit=%0b want 0", query_hit);
        end
    endtask

    task automatic test_reverse();
        do_dir(1);
        do_step();
        n_cmp++;
        if (head_x !== 6'd7 || head_y !== 6'd0) begin
            n_bad++;
            $display("FAIL reverse_ignored: head=(%0d,%0d) want (7,0)", head_x, head_y);
        end
        do_dir(2);
        do_step();
        n_cmp++;
        if (head_x !== 6'd7 || head_y !== 6'd1) begin
            n_bad++;
            $display("FAIL turn_down: head=(%0d,%0d) want (7,1)", head_x, head_y);
        end
    endtask

    task automatic test_grow();
        int tx, ty;
        for (int k = 0; k < 12; k++) begin
            tx = mx[mx.size() - 1];
            ty = my[my.size() - 1];
            do_grow();
            do_step();
            n_cmp++;
            if (length !== 5'(k + 5) || int'(length) != mx.size()) begin
                n_bad++;
                $display("FAIL grow_len: len=%0d want %0d", length, k + 5);
            end
            do_query(tx, ty);
            n_cmp++;
            if (query_hit !== 1'b1 || query_seg !== 5'(e_seg)) begin
                n_bad++;
                $display("FAIL grow_old_tail: hit=%0b seg=%0d want 1 %0d", query_hit, query_seg, e_seg);
            end
        end
        do_grow();
        do_step();
        n_cmp++;
        if (length !== 5'd16 || head_y !== 6'(my[0])) begin
            n_bad++;
            $display("FAIL grow_saturate: len=%0d head_y=%0d want 16 %0d", length, head_y, my[0]);
        end
    endtask

    task automatic test_wall();
        do_init();
        do_dir(3);
        do_step();
        n_cmp++;
        if (died !== 1'b1 || running !== 1'b0 || head_x !== 6'd3 || head_y !== 6'd0) begin
            n_bad++;
            $display("FAIL wall_death: died=%0b run=%0b head=(%0d,%0d) want 1 0 (3,0)",
                     died, running, head_x, head_y);
        end
        do_query(0, 0);
        n_cmp++;
        if (died !== 1'b0 || query_hit !== 1'b1 || query_seg !== 5'd3) begin
            n_bad++;
            $display("FAIL wall_died_pulse: died=%0b hit=%0b seg=%0d want 0 1 3", died, query_hit, query_seg);
        end
        do_step();
        n_cmp++;
        if (head_x !== 6'd3 || head_y !== 6'd0 || length !== 5'd4 || died !== 1'b0) begin
            n_bad++;
            $display("FAIL dead_step_ignored: head=(%0d,%0d) len=%0d died=%0b want (3,0) 4 0",
                     head_x, head_y, length, died);
        end
    endtask

    task automatic test_self();
        do_init();
        do_grow();
        do_step();
        do_dir(2);
        do_step();
        do_dir(1);
        do_step();
        n_cmp++;
        if (length !== 5'd5 || died !== 1'b0 || head_x !== 6'd3 || head_y !== 6'd1) begin
            n_bad++;
            $display("FAIL self_setup: len=%0d died=%0b head=(%0d,%0d) want 5 0 (3,1)",
                     length, died, head_x, head_y);
        end
        do_dir(3);
        do_step();
        n_cmp++;
        if (died !== 1'b1 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL self_death: died=%0b run=%0b want 1 0", died, running);
        end
        do_init();
        do_dir(2);
        do_step();
        do_dir(1);
        do_step();
        do_dir(3);
        do_step();
        n_cmp++;
        if (died !== 1'b0 || running !== 1'b1 || head_x !== 6'd2 || head_y !== 6'd0 || length !== 5'd4) begin
            n_bad++;
            $display("FAIL tail_chase: died=%0b run=%0b head=(%0d,%0d) len=%0d want 0 1 (2,0) 4",
                     died, running, head_x, head_y, length);
        end
        do_dir(0);
        do_step();
        n_cmp++;
        if (died !== 1'b0 || head_x !== 6'd3 || head_y !== 6'd0) begin
            n_bad++;
            $display("FAIL tail_chase2: died=%0b head=(%0d,%0d) want 0 (3,0)", died, head_x, head_y);
        end
    endtask

    task automatic test_async_reset();
        do_init();
        do_step();
        do_step();
        do_query(5, 0);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (head_x !== 6'd3 || head_y !== 6'd0 || length !== 5'd4 || running !== 1'b0 ||
            died !== 1'b0 || query_hit !== 1'b0 || query_seg !== 5'd0) begin
            n_bad++;
            $display("FAIL async_reset: head=(%0d,%0d) len=%0d run=%0b died=%0b qhit=%0b qseg=%0d",
                     head_x, head_y, length, running, died, query_hit, query_seg);
        end
        m_reset_model();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_step();
        n_cmp++;
        if (head_x !== 6'd3 || running !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_idle: head_x=%0d run=%0b want 3 0", head_x, running);
        end
    endtask

    task automatic test_init_step();
        do_init();
        do_step();
        do_step();
        drive_cycle(1, 1, 0, 0, 0, 0, 0);
        n_cmp++;
        if (head_x !== 6'd3 || head_y !== 6'd0 || length !== 5'd4 || running !== 1'b1) begin
            n_bad++;
            $display("FAIL init_beats_step: head=(%0d,%0d) len=%0d run=%0b want (3,0) 4 1",
                     head_x, head_y, length, running);
        end
    endtask

    task automatic test_random();
        int r, qx, qy, pick;
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                pick = $urandom_range(0, mx.size() - 1);
                qx = mx[pick];
                qy = my[pick];
            end else begin
                qx = $urandom_range(0, 15);
                qy = $urandom_range(0, 15);
            end
            r = $urandom_range(0, 99);
            if (m_state != 1 && $urandom_range(0, 3) == 0) r = 0;
            if (r < 3)       drive_cycle(1, 0, 0, 0, 0, qx, qy);
            else if (r < 45) drive_cycle(0, 1, 0, 0, 0, qx, qy);
            else if (r < 75) drive_cycle(0, 0, 1, $urandom_range(0, 3), 0, qx, qy);
            else if (r < 85) drive_cycle(0, 0, 0, 0, 1, qx, qy);
            else             drive_cycle(0, 0, 0, 0, 0, qx, qy);
            n_cmp++;
            if (head_x !== 6'(mx[0]) || head_y !== 6'(my[0]) || length !== 5'(mx.size()) ||
                running !== (m_state == 1) || died !== m_died || query_hit !== e_hit ||
                (e_hit && query_seg !== 5'(e_seg))) begin
                n_bad++;
                $display("FAIL random[%0d]: head=(%0d,%0d) len=%0d run=%0b died=%0b qhit=%0b qseg=%0d want (%0d,%0d) %0d %0b %0b %0b %0d",
                         n, head_x, head_y, length, running, died, query_hit, query_seg,
                         mx[0], my[0], mx.size(), (m_state == 1), m_died, e_hit, e_seg);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        m_reset_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_basic();
        test_reverse();
        test_grow();
        test_wall();
        test_self();
        test_async_reset();
        test_init_step();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
